mshr_ctrl: RTL and testbench
============================

Name: mshr_ctrl

Overview:
- Allocation and scheduling controller in front of the dcache `mshr` array.
- Accepts core miss allocations, detects secondary misses to an address already tracked, and issues pending entries to the bus in round-robin order.
- Frees entries on bus response and answers snoop lookups.
- Sole driver of the `mshr` write port: `we`, `adr`, `valid`, `transient_state`, `wrPtr`.

Parameters:
- MSHR_AW, 2, entry index width; depth N = 2**MSHR_AW.
- ADR_W, DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH, line address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; one clock, asynchronous, active-low.
- alloc_valid_i  in  1  core miss request.
- alloc_ready_o  out  1  request accepted when valid&ready.
- alloc_adr_i  in  ADR_W  miss line address.
- alloc_state_i  in  transient_state_t  initial transient state (IS, IM, MI...).
- alloc_merge_o  out  1  registered pulse: the accepted request matched a live entry.
- alloc_id_o  out  MSHR_AW  registered: entry id for the accepted request (new or existing).
- full_o  out  1  all entries busy.
- issue_valid_o  out  1  bus request available.
- issue_ready_i  in  1  bus accepts the request.
- issue_id_o  out  MSHR_AW  id of the issued entry.
- issue_adr_o  out  ADR_W  address of the issued entry.
- issue_state_o  out  transient_state_t  state of the issued entry.
- rsp_valid_i  in  1  bus response completes an entry.
- rsp_id_i  in  MSHR_AW  id of the completed entry.
- err_o  out  1  registered pulse: response for an entry not in WAIT.
- snoop_valid_i  in  1  snoop lookup.
- snoop_adr_i  in  ADR_W  snoop address.
- snoop_hit_o  out  1  lookup result, 1 cycle after request.
- snoop_id_o  out  MSHR_AW  lookup result, 1 cycle after request.
- snoop_state_o  out  transient_state_t  lookup result, 1 cycle after request.
- mshr_we_o  out  1  MSHR write port, registered.
- mshr_wrPtr_o  out  MSHR_AW  MSHR write port, registered.
- mshr_adr_o  out  ADR_W  MSHR write port, registered.
- mshr_valid_o  out  1  MSHR write port, registered.
- mshr_state_o  out  transient_state_t  MSHR write port, registered.

Behaviour:
- Per-entry FSM: FREE -> PEND on new allocation -> WAIT on issue handshake -> FREE on response. Each entry also holds an address copy and a state copy.
- Reset, asynchronous: all entries FREE; round-robin pointer = 0; every output 0, full_o = 0, state outputs = II. Mid-operation reset discards all entries; there is no MSHR write during reset.
- alloc_ready_o = !full_o && !rsp_valid_i. The response owns the write port, so an allocation stalls in any cycle a response arrives.
- Merge: an accepted alloc whose address equals a non-FREE entry's address:
  - allocates nothing and writes nothing;
  - next cycle: alloc_merge_o = 1, alloc_id_o = matching id.
- Merge is checked before the full check. A merge is accepted even when full_o = 1, so alloc_ready_o also rises in that case.
- New allocation:
  - takes the lowest-index FREE entry and sets it to PEND;
  - next cycle: alloc_id_o = that id, alloc_merge_o = 0, and the MSHR write port carries we = 1, valid = 1, that id, address and state.
- Issue arbitration:
  - issue_valid_o is asserted when any entry is PEND;
  - the granted id is the first PEND at or after the round-robin pointer, wrapping from N-1 to 0;
  - issue outputs stay stable until issue_ready_i;
  - on handshake the entry moves to WAIT and the pointer becomes grant+1 mod N.
- Response:
  - rsp_valid_i with rsp_id_i in WAIT: entry moves to FREE; next cycle the MSHR write port carries we = 1, valid = 0, state = II, that id, stored address.
  - Response to a FREE or PEND entry: no state change, no write, err_o pulses for 1 cycle.
- Snoop: compare against all non-FREE entries, using contents from before the edge. A snoop in the same cycle as an alloc or response does not see that cycle's update.
- Snoop results are registered. On a miss: snoop_hit_o = 0, snoop_id_o = 0, snoop_state_o = II.
- Same-cycle issue handshake and response on the same id: the response is ignored with err_o, since the entry was PEND before the edge.
- full_o = all entries non-FREE. It is combinational from the entry states, so it falls in the cycle after a response frees an entry.
- Between write events the registered outputs mshr_we_o, alloc_merge_o and err_o return to 0; the other MSHR port outputs hold their last value.

Decomposition:
- param_pkg holds DCACHE_TAG_WIDTH, DCACHE_INDEX_WIDTH, MSHR_AW, transient_state_t, and a new enum mshr_ent_t {ENT_FREE, ENT_PEND, ENT_WAIT}.
- One sub-module: rr_arbiter (N-bit request vector plus pointer -> one-hot grant and index), reusable by the interconnect.

Test Plan:
- Reset, then alloc 0x11111111/MI -> alloc_id_o = 0, mshr_we_o = 1, wrPtr = 0, valid = 1, state = MI one cycle later; issue_valid_o = 1 with issue_id_o = 0.
- Alloc 0x1/IS, then 0x1/IS again -> second gives alloc_merge_o = 1, alloc_id_o = 1, no MSHR write.
- Fill all 4 entries -> full_o = 1 and alloc_ready_o = 0 for a new address; alloc of an existing address is still merged.
- Entries 0-3 PEND, pointer 0, issue_ready_i held high -> grants 0, 1, 2, 3. Then rsp for id 2 and a new alloc -> the new entry is id 2 and is issued next, after the pointer wraps.
- Alloc and rsp_valid_i (id 1, WAIT) in the same cycle -> alloc_ready_o = 0; MSHR write of wrPtr = 1, valid = 0, state = II; the alloc is accepted next cycle into id 1.
- Snoop 0x11111111 while entry 0 is WAIT -> snoop_hit_o = 1, id = 0, state = MI. rsp for a FREE id -> err_o pulses and state is unchanged. Assert resetn = 0 mid-traffic -> all outputs 0 immediately.

Source files
------------

// File: rtl/param_pkg.sv
// param_pkg: dcache geometry, MSHR sizing and the shared transient/entry state types.
package param_pkg;
    localparam int DCACHE_TAG_WIDTH   = 24;
    localparam int DCACHE_INDEX_WIDTH = 8;
    localparam int MSHR_AW            = 2;
    typedef enum logic [2:0] {II, IS, IM, SM, MI, SI} transient_state_t;
    typedef enum logic [1:0] {ENT_FREE, ENT_PEND, ENT_WAIT} mshr_ent_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or after ptr_i, wrapping; one-hot grant plus index.
module rr_arbiter #(
    parameter int AW = 2,
    parameter int N  = 1 << AW
) (
    input  logic [N-1:0]  req_i,
    input  logic [AW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [AW-1:0] idx_o
);
    logic [AW-1:0] j;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        // Walk from the farthest offset down so the nearest request wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = ptr_i + AW'(k);
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/mshr_ctrl.sv
// mshr_ctrl: allocates, merges, issues (round-robin) and retires MSHR entries;
// sole driver of the MSHR write port, also answers snoop lookups.
module mshr_ctrl
    import param_pkg::*;
#(
    parameter int MSHR_AW = param_pkg::MSHR_AW,
    parameter int ADR_W   = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic [ADR_W-1:0]     alloc_adr_i,
    input  transient_state_t     alloc_state_i,
    output logic                 alloc_merge_o,
    output logic [MSHR_AW-1:0]   alloc_id_o,
    output logic                 full_o,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [MSHR_AW-1:0]   issue_id_o,
    output logic [ADR_W-1:0]     issue_adr_o,
    output transient_state_t     issue_state_o,
    input  logic                 rsp_valid_i,
    input  logic [MSHR_AW-1:0]   rsp_id_i,
    output logic                 err_o,
    input  logic                 snoop_valid_i,
    input  logic [ADR_W-1:0]     snoop_adr_i,
    output logic                 snoop_hit_o,
    output logic [MSHR_AW-1:0]   snoop_id_o,
    output transient_state_t     snoop_state_o,
    output logic                 mshr_we_o,
    output logic [MSHR_AW-1:0]   mshr_wrPtr_o,
    output logic [ADR_W-1:0]     mshr_adr_o,
    output logic                 mshr_valid_o,
    output transient_state_t     mshr_state_o
);
    localparam int N = 1 << MSHR_AW;

    mshr_ent_t        ent_q [N], ent_d [N];
    logic [ADR_W-1:0] adr_q [N], adr_d [N];
    transient_state_t st_q  [N], st_d  [N];
    logic [MSHR_AW-1:0] ptr_q, ptr_d, aid_q, aid_d, wr_q, wr_d, sid_q, sid_d;
    logic [ADR_W-1:0] madr_q, madr_d;
    transient_state_t mst_q, mst_d, sst_q, sst_d;
    logic merge_q, merge_d, err_q, err_d, we_q, we_d, mvalid_q, mvalid_d, shit_q, shit_d;

    logic [N-1:0] busy, pend, gnt;
    logic [MSHR_AW-1:0] gnt_idx, free_idx, amatch_idx, smatch_idx;
    logic amatch, smatch, alloc_fire;

    always_comb begin
        busy = '0;
        pend = '0;
        amatch = 1'b0;
        smatch = 1'b0;
        amatch_idx = '0;
        smatch_idx = '0;
        free_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            busy[k] = ent_q[k] != ENT_FREE;
            pend[k] = ent_q[k] == ENT_PEND;
            if (!busy[k]) free_idx = MSHR_AW'(k);
            if (busy[k] && adr_q[k] == alloc_adr_i) begin
                amatch = 1'b1;
                amatch_idx = MSHR_AW'(k);
            end
            if (busy[k] && adr_q[k] == snoop_adr_i) begin
                smatch = 1'b1;
                smatch_idx = MSHR_AW'(k);
            end
        end
    end

    rr_arbiter #(.AW(MSHR_AW)) u_arb (
        .req_i (pend),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign full_o        = &busy;
    assign alloc_ready_o = resetn && !rsp_valid_i && (amatch || !full_o);
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign issue_valid_o = |gnt;
    assign issue_id_o    = gnt_idx;
    assign issue_adr_o   = issue_valid_o ? adr_q[gnt_idx] : '0;
    assign issue_state_o = issue_valid_o ? st_q[gnt_idx] : II;

    always_comb begin
        ent_d = ent_q;
        adr_d = adr_q;
        st_d = st_q;
        ptr_d = ptr_q;
        we_d = 1'b0;
        wr_d = wr_q;
        madr_d = madr_q;
        mvalid_d = mvalid_q;
        mst_d = mst_q;
        merge_d = 1'b0;
        aid_d = aid_q;
        err_d = 1'b0;
        // Parking the pointer on a stalled grant keeps the issue outputs stable.
        if (issue_valid_o) begin
            ptr_d = issue_ready_i ? gnt_idx + 1'b1 : gnt_idx;
            if (issue_ready_i) ent_d[gnt_idx] = ENT_WAIT;
        end
        if (rsp_valid_i) begin
            if (ent_q[rsp_id_i] == ENT_WAIT) begin
                ent_d[rsp_id_i] = ENT_FREE;
                we_d = 1'b1;
                wr_d = rsp_id_i;
                madr_d = adr_q[rsp_id_i];
                mvalid_d = 1'b0;
                mst_d = II;
            end else begin
                err_d = 1'b1;
            end
        end
        if (alloc_fire) begin
            merge_d = amatch;
            aid_d = amatch ? amatch_idx : free_idx;
            if (!amatch) begin
                ent_d[free_idx] = ENT_PEND;
                adr_d[free_idx] = alloc_adr_i;
                st_d[free_idx] = alloc_state_i;
                we_d = 1'b1;
                wr_d = free_idx;
                madr_d = alloc_adr_i;
                mvalid_d = 1'b1;
                mst_d = alloc_state_i;
            end
        end
        shit_d = snoop_valid_i && smatch;
        sid_d = shit_d ? smatch_idx : '0;
        sst_d = shit_d ? st_q[smatch_idx] : II;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N; k++) begin
                ent_q[k] <= ENT_FREE;
                adr_q[k] <= '0;
                st_q[k] <= II;
            end
            ptr_q <= '0;
            we_q <= 1'b0;
            wr_q <= '0;
            madr_q <= '0;
            mvalid_q <= 1'b0;
            mst_q <= II;
            merge_q <= 1'b0;
            aid_q <= '0;
            err_q <= 1'b0;
            shit_q <= 1'b0;
            sid_q <= '0;
            sst_q <= II;
        end else begin
            ent_q <= ent_d;
            adr_q <= adr_d;
            st_q <= st_d;
            ptr_q <= ptr_d;
            we_q <= we_d;
            wr_q <= wr_d;
            madr_q <= madr_d;
            mvalid_q <= mvalid_d;
            mst_q <= mst_d;
            merge_q <= merge_d;
            aid_q <= aid_d;
            err_q <= err_d;
            shit_q <= shit_d;
            sid_q <= sid_d;
            sst_q <= sst_d;
        end
    end

    assign alloc_merge_o = merge_q;
    assign alloc_id_o    = aid_q;
    assign err_o         = err_q;
    assign snoop_hit_o   = shit_q;
    assign snoop_id_o    = sid_q;
    assign snoop_state_o = sst_q;
    assign mshr_we_o     = we_q;
    assign mshr_wrPtr_o  = wr_q;
    assign mshr_adr_o    = madr_q;
    assign mshr_valid_o  = mvalid_q;
    assign mshr_state_o  = mst_q;
endmodule

// File: tb/tb_mshr_ctrl.sv
// tb_mshr_ctrl: randomized traffic against a queue/array reference model of the MSHR controller.
module tb_mshr_ctrl;
    import param_pkg::*;
    localparam int AW = 2;
    localparam int N = 4;
    localparam int AD = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

    logic clk = 0, resetn = 0;
    logic alloc_valid = 0, issue_ready = 0, rsp_valid = 0, snoop_valid = 0;
    logic [AD-1:0] alloc_adr = 0, snoop_adr = 0;
    transient_state_t alloc_state = II;
    logic [AW-1:0] rsp_id = 0;
    logic alloc_ready, alloc_merge, full, issue_valid, err, snoop_hit, mshr_we, mshr_valid;
    logic [AW-1:0] alloc_id, issue_id, snoop_id, mshr_wrptr;
    logic [AD-1:0] issue_adr, mshr_adr;
    transient_state_t issue_state, snoop_state, mshr_state;

    mshr_ctrl dut (
        .clk(clk), .resetn(resetn),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_adr_i(alloc_adr),
        .alloc_state_i(alloc_state), .alloc_merge_o(alloc_merge), .alloc_id_o(alloc_id),
        .full_o(full), .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .issue_id_o(issue_id), .issue_adr_o(issue_adr), .issue_state_o(issue_state),
        .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id), .err_o(err),
        .snoop_valid_i(snoop_valid), .snoop_adr_i(snoop_adr), .snoop_hit_o(snoop_hit),
        .snoop_id_o(snoop_id), .snoop_state_o(snoop_state),
        .mshr_we_o(mshr_we), .mshr_wrPtr_o(mshr_wrptr), .mshr_adr_o(mshr_adr),
        .mshr_valid_o(mshr_valid), .mshr_state_o(mshr_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    localparam int FR = 0, PD = 1, WT = 2;
    int m_ent [N];
    logic [AD-1:0] m_adr [N];
    logic [2:0] m_st [N];
    int m_ptr, m_lock;
    logic e_merge, e_err, e_we, e_mvalid, e_shit;
    logic [AW-1:0] e_aid, e_wr, e_sid;
    logic [AD-1:0] e_madr;
    logic [2:0] e_mst, e_sst;
    logic [AD-1:0] pool [6] = '{32'h11111111, 32'h1, 32'h22, 32'h33, 32'h44, 32'h55};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ent[i] = FR;
            m_adr[i] = 0;
            m_st[i] = 3'(II);
        end
        m_ptr = 0;
        m_lock = -1;
        {e_merge, e_err, e_we, e_mvalid, e_shit} = '0;
        {e_aid, e_wr, e_sid, e_madr, e_mst, e_sst} = '0;
    endtask

    task automatic check_regs(input string when);
        check({when, ".merge"}, alloc_merge, e_merge);
        check({when, ".aid"}, alloc_id, e_aid);
        check({when, ".err"}, err, e_err);
        check({when, ".we"}, mshr_we, e_we);
        check({when, ".wrptr"}, mshr_wrptr, e_wr);
        check({when, ".madr"}, mshr_adr, e_madr);
        check({when, ".mvalid"}, mshr_valid, e_mvalid);
        check({when, ".mstate"}, mshr_state, e_mst);
        check({when, ".shit"}, snoop_hit, e_shit);
        check({when, ".sid"}, snoop_id, e_sid);
        check({when, ".sstate"}, snoop_state, e_sst);
    endtask

    // Inputs are already driven; check combinational outputs, advance the model, check registers.
    task automatic cycle();
        bit fl, am, sm, ready, iv, ok;
        int mid, sid, fid, gid;
        #3;
        fl = 1; am = 0; sm = 0; mid = 0; sid = 0; fid = -1; iv = 0; gid = 0;
        for (int i = 0; i < N; i++) begin
            if (m_ent[i] == FR) begin
                fl = 0;
                if (fid < 0) fid = i;
            end else begin
                if (!am && m_adr[i] == alloc_adr) begin am = 1; mid = i; end
                if (!sm && m_adr[i] == snoop_adr) begin sm = 1; sid = i; end
            end
        end
        ready = !rsp_valid && (am || !fl);
        if (m_lock >= 0) begin
            iv = 1;
            gid = m_lock;
        end else begin
            for (int k = 0; k < N; k++)
                if (!iv && m_ent[(m_ptr + k) % N] == PD) begin iv = 1; gid = (m_ptr + k) % N; end
        end
        check("full", full, fl);
        check("alloc_ready", alloc_ready, ready);
        check("issue_valid", issue_valid, iv);
        check("issue_id", issue_id, iv ? gid : 0);
        check("issue_adr", issue_adr, iv ? m_adr[gid] : 0);
        check("issue_state", issue_state, iv ? m_st[gid] : 3'(II));
        ok = rsp_valid && m_ent[rsp_id] == WT;
        e_merge = 0; e_err = 0; e_we = 0;
        e_shit = snoop_valid && sm;
        e_sid = e_shit ? AW'(sid) : '0;
        e_sst = e_shit ? m_st[sid] : 3'(II);
        if (iv) begin
            if (issue_ready) begin
                m_ent[gid] = WT;
                m_ptr = (gid + 1) % N;
                m_lock = -1;
            end else m_lock = gid;
        end
        if (rsp_valid) begin
            if (ok) begin
                m_ent[rsp_id] = FR;
                e_we = 1; e_wr = rsp_id; e_madr = m_adr[rsp_id]; e_mvalid = 0; e_mst = 3'(II);
            end else e_err = 1;
        end
        if (alloc_valid && ready) begin
            e_merge = am;
            e_aid = am ? AW'(mid) : AW'(fid);
            if (!am) begin
                m_ent[fid] = PD; m_adr[fid] = alloc_adr; m_st[fid] = 3'(alloc_state);
                e_we = 1; e_wr = AW'(fid); e_madr = alloc_adr; e_mvalid = 1; e_mst = 3'(alloc_state);
            end
        end
        @(posedge clk);
        #1;
        check_regs("cyc");
    endtask

    task automatic idle();
        alloc_valid = 0; issue_ready = 0; rsp_valid = 0; snoop_valid = 0;
    endtask

    task automatic reset_checks();
        check("rst.ready", alloc_ready, 0);
        check("rst.full", full, 0);
        check("rst.ivalid", issue_valid, 0);
        check("rst.iid", issue_id, 0);
        check("rst.iadr", issue_adr, 0);
        check("rst.istate", issue_state, II);
        check_regs("rst");
    endtask

    initial begin
        model_reset();
        idle();
        #12;
        reset_checks();
        @(posedge clk); #1;
        resetn = 1;
        // First allocation lands in entry 0 and becomes issuable.
        alloc_valid = 1; alloc_adr = 32'h11111111; alloc_state = MI;
        cycle();
        check("first.aid", alloc_id, 0);
        check("first.we", mshr_we, 1);
        check("first.wrptr", mshr_wrptr, 0);
        check("first.valid", mshr_valid, 1);
        check("first.state", mshr_state, MI);
        alloc_valid = 1; alloc_adr = 32'h1; alloc_state = IS;
        cycle();
        alloc_valid = 1; alloc_adr = 32'h1; alloc_state = IS;
        cycle();
        check("merge.flag", alloc_merge, 1);
        check("merge.id", alloc_id, 1);
        check("merge.nowe", mshr_we, 0);
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                idle();
                resetn = 0;
                model_reset();
                #1;
                reset_checks();
                @(posedge clk); #1;
                resetn = 1;
            end
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_adr = pool[$urandom_range(0, 5)];
            alloc_state = transient_state_t'($urandom_range(1, 5));
            issue_ready = $urandom_range(0, 1);
            rsp_valid = ($urandom_range(0, 9) < 3);
            rsp_id = AW'($urandom_range(0, N - 1));
            snoop_valid = $urandom_range(0, 1);
            snoop_adr = pool[$urandom_range(0, 5)];
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
